// File: rtl/bram_sdp_pipe.sv
// bram_sdp_pipe: simple dual-port block RAM with a free-running read pipeline of read_latency stages
module bram_sdp_pipe #(
  parameter int mem_width = 32,
  parameter int mem_depth = 4096,
  parameter int read_latency = 2,
  parameter string byte_write_mode = "false",
  parameter string INIT_FILE = "no_init",
  parameter int simulation_delay = 1,
  localparam int aw = $clog2(mem_depth) + 1,
  localparam int nb = (byte_write_mode == "true") ? mem_width / 8 : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [nb-1:0]        wen,
  input  logic [aw-1:0]        waddr,
  input  logic [mem_width-1:0] din,
  input  logic                 ren,
  input  logic [aw-1:0]        raddr,
  output logic [mem_width-1:0] dout,
  output logic                 dout_vld
);
  localparam int lw = mem_width / nb;
  localparam int iw = (mem_depth > 1) ? $clog2(mem_depth) : 1;
  localparam logic [aw-1:0] depth_a = aw'(mem_depth);
  if (read_latency < 1 || read_latency > 3 || simulation_delay < 0 ||
      (byte_write_mode == "true" && mem_width % 8 != 0)) begin : g_bad
    $error("bram_sdp_pipe: illegal parameter combination");
  end
  logic [mem_width-1:0] mem [mem_depth];
  logic [mem_width-1:0] rdata, fin_d;
  logic w_ok, r_ok, fin_v;
  assign w_ok = waddr < depth_a;
  assign r_ok = raddr < depth_a;
  initial
    for (int i = 0; i < mem_depth; i++)
      mem[i] = (INIT_FILE == "default") ? mem_width'(i) : '0;
  always_ff @(posedge clk)
    if (w_ok)
      for (int k = 0; k < nb; k++)
        if (wen[k]) mem[waddr[iw-1:0]][k*lw +: lw] <= din[k*lw +: lw];
`ifdef BRAM_SDP_FWD_EN
  always_comb begin
    rdata = r_ok ? mem[raddr[iw-1:0]] : '0;
    for (int k = 0; k < nb; k++)
      if (wen[k] && w_ok && waddr == raddr) rdata[k*lw +: lw] = din[k*lw +: lw];
  end
`else
  assign rdata = r_ok ? mem[raddr[iw-1:0]] : '0;
`endif
  if (read_latency == 1) begin : g_l1
    assign fin_d = rdata;
    assign fin_v = ren;
  end else begin : g_ln
    logic [mem_width-1:0] dq [read_latency-1];
    logic [read_latency-2:0] vq;
    always_ff @(posedge clk) begin
      dq[0] <= rdata;
      for (int i = 1; i < read_latency - 1; i++) dq[i] <= dq[i-1];
      if (rst) vq <= '0;
      else begin
        vq[0] <= ren;
        for (int i = 1; i < read_latency - 1; i++) vq[i] <= vq[i-1];
      end
    end
    assign fin_d = dq[read_latency-2];
    assign fin_v = vq[read_latency-2];
  end
  always_ff @(posedge clk)
    if (rst) begin
      dout <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= fin_v;
      if (fin_v) dout <= fin_d;
    end
endmodule

// File: tb/tb_bram_sdp_pipe.sv
// tb_bram_sdp_pipe: randomized check of bram_sdp_pipe against a queue-based memory model
module tb_bram_sdp_pipe;
  localparam int W = 32, D = 64, L = 3, NB = 4, AW = 7;
  logic clk = 1'b0, rst, ren, dout_vld;
  logic [NB-1:0] wen;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0] din, dout, last;
  logic [W-1:0] mdl [D];
  typedef struct {int due; logic [W-1:0] d;} rd_t;
  rd_t pend [$];
  int cyc, n_chk, n_pass;
  bram_sdp_pipe #(.mem_width(W), .mem_depth(D), .read_latency(L), .byte_write_mode("true"),
                  .INIT_FILE("default"), .simulation_delay(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout), .dout_vld(dout_vld));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask
  task automatic step(input logic r, input logic re, input int ra, input logic [NB-1:0] we,
                      input int wa, input logic [W-1:0] d);
    logic [W-1:0] rd;
    rst = r; ren = re; raddr = AW'(ra); wen = we; waddr = AW'(wa); din = d;
    if (r) begin
      pend.delete();
      last = '0;
    end else if (re) begin
      rd = mdl[ra];
`ifdef BRAM_SDP_FWD_EN
      for (int k = 0; k < NB; k++) if (we[k] && wa == ra) rd[8*k +: 8] = d[8*k +: 8];
`endif
      pend.push_back('{cyc + L, rd});
    end
    if (wa < D)
      for (int k = 0; k < NB; k++) if (we[k]) mdl[wa][8*k +: 8] = d[8*k +: 8];
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      check("vld", {31'd0, dout_vld}, 1);
      check("dout", dout, pend[0].d);
      last = pend[0].d;
      void'(pend.pop_front());
    end else begin
      check("vld_idle", {31'd0, dout_vld}, 0);
      check("hold", dout, last);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask
  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; last = '0;
    for (int i = 0; i < D; i++) mdl[i] = W'(i);
    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    check("rst_dout", dout, 0);
    step(0, 1, 5, '0, 0, '0);
    idle(L);
    check("lat_val", dout, 5);
    for (int i = 10; i < 14; i++) step(0, 1, i, '0, 0, '0);
    idle(L + 1);
    check("burst_last", dout, 13);
    step(0, 0, 0, 4'hF, 7, 32'h11223344);
    step(0, 0, 0, 4'b0101, 7, 32'hAABBCCDD);
    step(0, 1, 7, '0, 0, '0);
    idle(L);
    check("byte_lanes", dout, 32'h11BB33DD);
    step(0, 0, 0, 4'hF, 3, 32'h0);
    step(0, 1, 3, 4'hF, 3, 32'hDEADBEEF);
    idle(L);
`ifdef BRAM_SDP_FWD_EN
    check("collide", dout, 32'hDEADBEEF);
`else
    check("collide", dout, 32'h0);
`endif
    step(0, 1, 20, '0, 0, '0);
    step(1, 0, 0, 4'hF, 21, 32'h12345678);
    idle(L);
    check("rst_flush_dout", dout, 0);
    check("rst_flush_vld", {31'd0, dout_vld}, 0);
    step(0, 1, 20, '0, 0, '0);
    step(0, 1, 21, '0, 0, '0);
    idle(L);
    check("rst_write", dout, 32'h12345678);
    step(0, 0, 0, 4'hF, 64 + 9, 32'hFFFFFFFF);
    step(0, 1, 9, '0, 0, '0);
    idle(L);
    check("oob_drop", dout, 9);
    for (int n = 0; n < 600; n++) begin
      int ra, wa;
      ra = int'($urandom_range(0, D - 1));
      wa = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, D + 15));
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, ra, NB'($urandom), wa, $urandom);
    end
    idle(L + 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
